// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU command-issue stage.
// Holds opcodes, FSM states, the result flag bundle and datapath widths.
package alu_pkg;

    localparam int ALU_W   = 8;
    localparam int SHIFT_W = 4;
    localparam int OP_W    = 3;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_ASL = 3'b100,
        OP_ASR = 3'b101
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } cmd_state_e;

    typedef struct packed {
        logic zero;
        logic carry;
        logic ovf;
    } alu_flags_t;

endpackage

// File: rtl/alu_flag_reg.sv
// Accumulator and sticky carry/overflow register for the ALU command stage.
// Ports: clk, rst_n, clr (sync clear), cap (capture strobe), cap_y/cap_c/cap_v
// (captured ALU result and flags), acc, sticky_c, sticky_v (state outputs).
module alu_flag_reg
    import alu_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             cap,
    input  logic [ALU_W-1:0] cap_y,
    input  logic             cap_c,
    input  logic             cap_v,
    output logic [ALU_W-1:0] acc,
    output logic             sticky_c,
    output logic             sticky_v
);

    // A clear coincident with a capture wipes the history first, so the
    // sticky bits end up holding just the flags of the captured op.
    logic base_c;
    logic base_v;

    assign base_c = clr ? 1'b0 : sticky_c;
    assign base_v = clr ? 1'b0 : sticky_v;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            sticky_c <= 1'b0;
            sticky_v <= 1'b0;
        end else if (cap) begin
            acc      <= cap_y;
            sticky_c <= base_c | cap_c;
            sticky_v <= base_v | cap_v;
        end else if (clr) begin
            acc      <= '0;
            sticky_c <= 1'b0;
            sticky_v <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_cmd_stage.sv
// Command-issue and result-capture stage in front of an 8-bit ALU.
// Ports: clk/rst_n; in_* command handshake and operands; acc_clr;
// alu_* operand bus out and result/flags in; out_* result handshake;
// acc, sticky_c, sticky_v accumulator state.
module alu_cmd_stage
    import alu_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [OP_W-1:0]    in_op,
    input  logic [ALU_W-1:0]   in_a,
    input  logic [ALU_W-1:0]   in_b,
    input  logic [SHIFT_W-1:0] in_shift,
    input  logic               in_use_acc,
    input  logic               acc_clr,
    output logic [ALU_W-1:0]   alu_a,
    output logic [ALU_W-1:0]   alu_b,
    output logic [SHIFT_W-1:0] alu_shift,
    output logic [OP_W-1:0]    alu_s,
    input  logic [ALU_W-1:0]   alu_y,
    input  logic               alu_zero,
    input  logic               alu_carry,
    input  logic               alu_ovf,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ALU_W-1:0]   out_y,
    output logic [2:0]         out_flags,
    output logic [ALU_W-1:0]   acc,
    output logic               sticky_c,
    output logic               sticky_v
);

    cmd_state_e state;
    alu_flags_t flags_q;
    logic       cap;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == HOLD);
    assign out_flags = flags_q;
    assign cap       = (state == EXEC);

    // Illegal opcodes are latched as-is; the ALU decides what they mean.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_shift <= '0;
            alu_s     <= '0;
            out_y     <= '0;
            flags_q   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        alu_a     <= in_use_acc ? acc : in_a;
                        alu_b     <= in_b;
                        alu_shift <= in_shift;
                        alu_s     <= in_op;
                        state     <= EXEC;
                    end
                end
                EXEC: begin
                    out_y   <= alu_y;
                    flags_q <= '{zero:  alu_zero,
                                 carry: alu_carry,
                                 ovf:   alu_ovf};
                    state   <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    alu_flag_reg u_flag_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (acc_clr),
        .cap      (cap),
        .cap_y    (alu_y),
        .cap_c    (alu_carry),
        .cap_v    (alu_ovf),
        .acc      (acc),
        .sticky_c (sticky_c),
        .sticky_v (sticky_v)
    );

endmodule

// File: tb/tb_alu_cmd_stage.sv
// Testbench for alu_cmd_stage with a behavioural ALU and transaction model.
// Directed commands, cycle-by-cycle comparison and literal spot checks.
module tb_alu_cmd_stage;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [2:0] in_op = '0;
    logic [7:0] in_a = '0;
    logic [7:0] in_b = '0;
    logic [3:0] in_shift = '0;
    logic       in_use_acc = 1'b0;
    logic       acc_clr = 1'b0;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [3:0] alu_shift;
    logic [2:0] alu_s;
    logic [7:0] alu_y;
    logic       alu_zero;
    logic       alu_carry;
    logic       alu_ovf;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_y;
    logic [2:0] out_flags;
    logic [7:0] acc;
    logic       sticky_c;
    logic       sticky_v;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_cmd_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_shift   (in_shift),
        .in_use_acc (in_use_acc),
        .acc_clr    (acc_clr),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_shift  (alu_shift),
        .alu_s      (alu_s),
        .alu_y      (alu_y),
        .alu_zero   (alu_zero),
        .alu_carry  (alu_carry),
        .alu_ovf    (alu_ovf),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_y      (out_y),
        .out_flags  (out_flags),
        .acc        (acc),
        .sticky_c   (sticky_c),
        .sticky_v   (sticky_v)
    );

    // Reference ALU: returns {y, zero, carry, ovf}
    function automatic logic [10:0] alu_fn(input logic [2:0] op,
                                           input logic [7:0] a,
                                           input logic [7:0] b,
                                           input logic [3:0] sh);
        logic [8:0] s;
        logic [7:0] y;
        logic       c;
        logic       v;
        c = 1'b0;
        v = 1'b0;
        s = {1'b0, a} + {1'b0, b};
        case (op)
            3'd0: begin
                y = s[7:0];
                c = s[8];
                v = (a[7] == b[7]) && (y[7] != a[7]);
            end
            3'd1: begin
                y = a - b;
                c = (a < b);
                v = (a[7] != b[7]) && (y[7] != a[7]);
            end
            3'd2: y = a & b;
            3'd3: y = a | b;
            3'd4: y = s[7:0] << sh;
            3'd5: y = 8'($signed(s[7:0]) >>> sh);
            default: y = a ^ b;
        endcase
        return {y, (y == 8'h00), c, v};
    endfunction

    always_comb begin
        {alu_y, alu_zero, alu_carry, alu_ovf} =
            alu_fn(alu_s, alu_a, alu_b, alu_shift);
    end

    // Transaction model: one command in flight at most; its result becomes
    // visible one edge after acceptance and leaves on the handshake.
    logic       m_live = 1'b0;
    logic       m_done = 1'b0;
    logic [7:0] m_a = '0;
    logic [7:0] m_b = '0;
    logic [3:0] m_sh = '0;
    logic [2:0] m_op = '0;
    logic [7:0] m_y = '0;
    logic [2:0] m_f = '0;
    logic [7:0] m_acc = '0;
    logic       m_sc = 1'b0;
    logic       m_sv = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        logic [10:0] r;
        logic        captured;
        if (!rst_n) begin
            m_live = 1'b0;
            m_done = 1'b0;
            m_a = '0; m_b = '0; m_sh = '0; m_op = '0;
            m_y = '0; m_f = '0;
            m_acc = '0; m_sc = 1'b0; m_sv = 1'b0;
        end else begin
            captured = 1'b0;
            if (m_live && m_done) begin
                if (out_ready) m_live = 1'b0;
            end else if (m_live) begin
                r = alu_fn(m_op, m_a, m_b, m_sh);
                m_y = r[10:3];
                m_f = r[2:0];
                m_acc = r[10:3];
                m_sc = (acc_clr ? 1'b0 : m_sc) | r[1];
                m_sv = (acc_clr ? 1'b0 : m_sv) | r[0];
                m_done = 1'b1;
                captured = 1'b1;
            end else if (in_valid) begin
                m_a = in_use_acc ? m_acc : in_a;
                m_b = in_b;
                m_sh = in_shift;
                m_op = in_op;
                m_live = 1'b1;
                m_done = 1'b0;
            end
            if (acc_clr && !captured) begin
                m_acc = '0;
                m_sc = 1'b0;
                m_sv = 1'b0;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("in_ready", 32'(in_ready), 32'(!m_live));
        chk("out_valid", 32'(out_valid), 32'(m_live && m_done));
        chk("out_y", 32'(out_y), 32'(m_y));
        chk("out_flags", 32'(out_flags), 32'(m_f));
        chk("acc", 32'(acc), 32'(m_acc));
        chk("sticky_c", 32'(sticky_c), 32'(m_sc));
        chk("sticky_v", 32'(sticky_v), 32'(m_sv));
        chk("alu_a", 32'(alu_a), 32'(m_a));
        chk("alu_b", 32'(alu_b), 32'(m_b));
        chk("alu_s", 32'(alu_s), 32'(m_op));
        chk("alu_shift", 32'(alu_shift), 32'(m_sh));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents a command and returns #1 after the accepting edge.
    task automatic send(input logic [2:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [3:0] sh,
                        input logic ua);
        bit ok;
        ok = 1'b0;
        in_op = op;
        in_a = a;
        in_b = b;
        in_shift = sh;
        in_use_acc = ua;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (in_ready) begin
                step();
                ok = 1'b1;
                break;
            end
            step();
        end
        in_valid = 1'b0;
        in_use_acc = 1'b0;
        if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        // Reset
        repeat (3) step();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_y", 32'(out_y), 32'd0);
        chk("rst_acc", 32'(acc), 32'd0);
        chk("rst_sticky", 32'({sticky_c, sticky_v}), 32'd0);
        chk("rst_alu_a", 32'(alu_a), 32'd0);
        rst_n = 1'b1;
        step();

        // ADD 7F+01: overflow, latency
        send(3'd0, 8'h7F, 8'h01, 4'd0, 1'b0);
        chk("lat_exec_nv", 32'(out_valid), 32'd0);
        step();
        chk("lat_hold_v", 32'(out_valid), 32'd1);
        chk("add7f_y", 32'(out_y), 32'h80);
        chk("add7f_f", 32'(out_flags), 32'b001);
        chk("add7f_sv", 32'(sticky_v), 32'd1);
        step();

        // ADD FF+01 then SUB 05-05
        send(3'd0, 8'hFF, 8'h01, 4'd0, 1'b0);
        step();
        chk("addff_y", 32'(out_y), 32'h00);
        chk("addff_f", 32'(out_flags), 32'b110);
        step();
        send(3'd1, 8'h05, 8'h05, 4'd0, 1'b0);
        step();
        chk("sub_y", 32'(out_y), 32'h00);
        chk("sub_zero", 32'(out_flags[2]), 32'd1);
        chk("sub_sc", 32'(sticky_c), 32'd1);
        step();

        // Clear in IDLE, then accumulate
        acc_clr = 1'b1;
        step();
        acc_clr = 1'b0;
        chk("clr_acc", 32'(acc), 32'd0);
        chk("clr_sticky", 32'({sticky_c, sticky_v}), 32'd0);
        send(3'd0, 8'h10, 8'h20, 4'd0, 1'b0);
        step();
        chk("acc30", 32'(acc), 32'h30);
        step();
        send(3'd2, 8'hFF, 8'hF0, 4'd0, 1'b1);
        chk("useacc_a", 32'(alu_a), 32'h30);
        step();
        chk("and_acc_y", 32'(out_y), 32'h30);
        step();

        // Backpressure with a second command waiting
        out_ready = 1'b0;
        send(3'd3, 8'h0F, 8'hA0, 4'd0, 1'b0);
        step();
        in_op = 3'd4;
        in_a = 8'h01;
        in_b = 8'h02;
        in_shift = 4'd2;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_y", 32'(out_y), 32'hAF);
            chk("bp_f", 32'(out_flags), 32'b000);
            chk("bp_rdy", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        step();
        chk("bp_idle", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        chk("bp_acc2", 32'(in_ready), 32'd0);
        step();
        chk("asl_y", 32'(out_y), 32'h0C);
        step();

        // ASR and an illegal opcode
        send(3'd5, 8'h80, 8'h00, 4'd3, 1'b0);
        step();
        chk("asr_y", 32'(out_y), 32'hF0);
        step();
        send(3'd6, 8'h3C, 8'h0F, 4'd0, 1'b0);
        chk("ill_s", 32'(alu_s), 32'd6);
        step();
        chk("ill_y", 32'(out_y), 32'h33);
        step();

        // Clear coincident with capture
        send(3'd0, 8'h7F, 8'h01, 4'd0, 1'b0);
        step();
        step();
        send(3'd0, 8'h01, 8'h01, 4'd0, 1'b0);
        acc_clr = 1'b1;
        step();
        acc_clr = 1'b0;
        chk("clrcap_acc", 32'(acc), 32'h02);
        chk("clrcap_st", 32'({sticky_c, sticky_v}), 32'd0);
        chk("clrcap_y", 32'(out_y), 32'h02);
        step();

        // Reset during HOLD
        out_ready = 1'b0;
        send(3'd0, 8'h02, 8'h03, 4'd0, 1'b0);
        step();
        chk("pre_rst_v", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_v", 32'(out_valid), 32'd0);
        chk("arst_y", 32'(out_y), 32'd0);
        chk("arst_rdy", 32'(in_ready), 32'd1);
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        chk("post_rst_v", 32'(out_valid), 32'd0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
